// File: rtl/dlatch_tester.sv
// Drives an external D latch through a pseudo-random gate/data sequence,
// compares its synchronized Q against the expected latched value and reports the result.
module dlatch_tester #(
  parameter int NUM_VECTORS = 64,
  parameter int SETTLE      = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  output logic       Gate_Out,
  output logic       D_Out,
  input  logic       Q_In,
  output logic       Busy,
  output logic       Done,
  output logic       Pass,
  output logic [7:0] Err_Count,
  output logic [7:0] Vec_Count
);

  localparam int       CW   = $clog2(SETTLE);
  localparam logic [7:0] SEED = 8'hA5;
  localparam logic [7:0] NV8  = 8'(NUM_VECTORS);

  typedef enum logic [2:0] {
    S_IDLE, S_DRIVE, S_SETTLE, S_CHECK, S_DONE
  } state_t;

  state_t          state, next_state;
  logic [CW-1:0]   cnt;
  logic [7:0]      lfsr;
  logic [1:0]      q_pipe;
  logic            q_sync;
  logic            exp;
  logic            settle_last;
  logic            last_vec;
  logic            mismatch;

  assign q_sync      = q_pipe[1];
  assign settle_last = (cnt == CW'(SETTLE - 1));
  assign last_vec    = ((Vec_Count + 8'd1) == NV8);
  assign mismatch    = (q_sync != exp);

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE,
      S_DONE:   if (Start) next_state = S_DRIVE;
      S_DRIVE:  next_state = S_SETTLE;
      S_SETTLE: if (settle_last) next_state = S_CHECK;
      S_CHECK:  next_state = last_vec ? S_DONE : S_DRIVE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Gate_Out  <= 1'b0;
      D_Out     <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Pass      <= 1'b0;
      Err_Count <= 8'd0;
      Vec_Count <= 8'd0;
      exp       <= 1'b0;
      q_pipe    <= 2'b00;
      lfsr      <= SEED;
      cnt       <= '0;
    end else begin
      q_pipe <= {q_pipe[0], Q_In};
      case (state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            Err_Count <= 8'd0;
            Vec_Count <= 8'd0;
            Pass      <= 1'b0;
            Done      <= 1'b0;
            Busy      <= 1'b1;
            lfsr      <= SEED;
            cnt       <= '0;
          end
        end
        S_DRIVE: begin
          // Even vectors open the gate and load new data; odd vectors test the hold.
          Gate_Out <= ~Vec_Count[0];
          D_Out    <= lfsr[0];
          if (!Vec_Count[0]) exp <= lfsr[0];
          cnt      <= '0;
        end
        S_SETTLE: cnt <= cnt + 1'b1;
        S_CHECK: begin
          if (mismatch && Err_Count != 8'hFF) Err_Count <= Err_Count + 8'd1;
          Vec_Count <= Vec_Count + 8'd1;
          lfsr      <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
          if (last_vec) begin
            Busy     <= 1'b0;
            Done     <= 1'b1;
            Pass     <= (Err_Count == 8'd0) && !mismatch;
            Gate_Out <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dlatch_tester.sv
// Randomized self-checking bench for dlatch_tester against a vector-level model of the run.
module tb_dlatch_tester;
  localparam int NV = 64;
  localparam int ST = 4;
  localparam int VL = ST + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1, start = 1'b0, start1 = 1'b0;
  logic       gate, d, busy, done, pass, q_in;
  logic [7:0] err, vec;
  logic       gate1, d1, busy1, done1, pass1;
  logic [7:0] err1, vec1;
  logic       lq = 1'b0, lq1 = 1'b0;
  int         mode = 0;
  int         checks = 0, errors = 0;
  bit         md[NV];

  // Ideal latch: transparent while gate is high, sampled mid-cycle when inputs are stable.
  always @(negedge clk) begin
    if (gate)  lq  <= d;
    if (gate1) lq1 <= d1;
  end

  assign q_in = (mode == 0) ? lq : (mode == 1) ? 1'b0 : d;

  dlatch_tester #(.NUM_VECTORS(NV), .SETTLE(ST)) u_dut (
    .Clk(clk), .Reset(reset), .Start(start), .Gate_Out(gate), .D_Out(d), .Q_In(q_in),
    .Busy(busy), .Done(done), .Pass(pass), .Err_Count(err), .Vec_Count(vec));

  dlatch_tester #(.NUM_VECTORS(1), .SETTLE(ST)) u_dut1 (
    .Clk(clk), .Reset(reset), .Start(start1), .Gate_Out(gate1), .D_Out(d1), .Q_In(lq1),
    .Busy(busy1), .Done(done1), .Pass(pass1), .Err_Count(err1), .Vec_Count(vec1));

  function automatic void build_model();
    logic [7:0] s = 8'hA5;
    for (int k = 0; k < NV; k++) begin
      md[k] = s[0];
      s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    end
  endfunction

  // Expected errors: exp follows D on even vectors; q is what the wired latch presents.
  function automatic int model_errs(input int m);
    bit e = 0, q;
    int n = 0;
    for (int k = 0; k < NV; k++) begin
      if (k % 2 == 0) e = md[k];
      q = (m == 0) ? e : (m == 1) ? 1'b0 : md[k];
      if (q != e) n++;
    end
    return n;
  endfunction

  task automatic check_vec_cycle(input int c);
    int k;
    if (c % VL == 1 && c / VL < NV) begin
      k = c / VL;
      checks++;
      if (d !== md[k] || gate !== (k % 2 == 0) || vec !== 8'(k)) begin
        errors++;
        $display("FAIL vec%0d: d=%b gate=%b vec=%0d, want d=%b gate=%b vec=%0d",
                 k, d, gate, vec, md[k], (k % 2 == 0), k);
      end
    end
  endtask

  task automatic do_run(input int m, input bit noise);
    int c = 0;
    int ee = model_errs(m);
    mode = m;
    repeat ($urandom_range(1, 4)) @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    while (busy === 1'b1 && c < 2000) begin
      check_vec_cycle(c);
      if (noise) start = (c < NV * VL - 20) ? 1'($urandom % 2) : 1'b0;
      c++;
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (c !== NV * VL) begin
      errors++; $display("FAIL busy_len m%0d: got %0d want %0d", m, c, NV * VL);
    end
    checks++;
    if (done !== 1'b1 || pass !== (ee == 0) || err !== 8'(ee) || vec !== 8'(NV) || gate !== 1'b0) begin
      errors++;
      $display("FAIL result m%0d: done=%b pass=%b err=%0d vec=%0d gate=%b, want 1 %b %0d %0d 0",
               m, done, pass, err, vec, gate, (ee == 0), ee, NV);
    end
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || err !== 8'(ee) || vec !== 8'(NV) || gate !== 1'b0) begin
        errors++; $display("FAIL done_hold m%0d: done=%b busy=%b err=%0d vec=%0d", m, done, busy, err, vec);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      checks++;
      if ({gate, d, busy, done, pass, err, vec} !== 21'd0) begin
        errors++; $display("FAIL reset_idle: outs=%h want 0", {gate, d, busy, done, pass, err, vec});
      end
    end
  endtask

  task automatic test_ideal();      do_run(0, 1'b1); endtask

  task automatic test_tied_low();
    checks++;
    if (model_errs(1) == 0) begin errors++; $display("FAIL tied_model: got 0 want nonzero"); end
    do_run(1, 1'b0);
  endtask

  task automatic test_direct();     do_run(2, 1'b0); endtask

  task automatic test_reset_mid_run();
    mode = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      check_vec_cycle(c);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({gate, d, busy, done, pass, err, vec} !== 21'd0) begin
      errors++; $display("FAIL mid_reset: outs=%h want 0", {gate, d, busy, done, pass, err, vec});
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL mid_reset_done: got %b want 0", done); end
    do_run(0, 1'b0);
  endtask

  task automatic test_start_held();
    int c = 0;
    mode = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    while (done !== 1'b1 && c < 2000) begin
      check_vec_cycle(c);
      c++;
      @(negedge clk);
    end
    checks++;
    if (c !== NV * VL || pass !== 1'b1 || err !== 8'd0 || vec !== 8'(NV)) begin
      errors++; $display("FAIL held_run: cycles=%0d pass=%b err=%0d vec=%0d, want %0d 1 0 %0d",
                         c, pass, err, vec, NV * VL, NV);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || vec !== 8'd0 || err !== 8'd0 || pass !== 1'b0) begin
      errors++; $display("FAIL held_restart: done=%b busy=%b vec=%0d err=%0d pass=%b, want 0 1 0 0 0",
                         done, busy, vec, err, pass);
    end
    start = 1'b0;
    c = 0;
    while (done !== 1'b1 && c < 2000) begin c++; @(negedge clk); end
    checks++;
    if (done !== 1'b1 || vec !== 8'(NV) || pass !== 1'b1) begin
      errors++; $display("FAIL held_second: done=%b vec=%0d pass=%b want 1 %0d 1", done, vec, pass, NV);
    end
  endtask

  task automatic test_single_vector();
    int c = 0;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    @(negedge clk);
    while (done1 !== 1'b1 && c < 200) begin c++; @(negedge clk); end
    checks++;
    if (c !== VL || vec1 !== 8'd1 || pass1 !== 1'b1 || err1 !== 8'd0 || busy1 !== 1'b0) begin
      errors++; $display("FAIL single: cycles=%0d vec=%0d pass=%b err=%0d busy=%b, want %0d 1 1 0 0",
                         c, vec1, pass1, err1, busy1, VL);
    end
  endtask

  initial begin
    build_model();
    test_reset();
    test_ideal();
    test_tied_low();
    test_direct();
    test_reset_mid_run();
    test_start_held();
    test_single_vector();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
